// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared game-state and fade-state encodings plus colour constants
//            used by the output compositor.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

   // Game states as driven by the game controller; any other code shows black.
   typedef enum logic [2:0] {
      ST_START = 3'd1,
      ST_PLAY  = 3'd2,
      ST_WIN   = 3'd3,
      ST_OVER  = 3'd4
   } game_state_t;

   // Fade sequencer states.
   typedef enum logic [1:0] {
      FS_IDLE     = 2'd0,
      FS_FADE_OUT = 2'd1,
      FS_FADE_IN  = 2'd2
   } fade_state_t;

   // Default bits per colour channel and number of channels per pixel.
   localparam int RGB_CH_W = 4;
   localparam int NUM_CH   = 3;

endpackage
`default_nettype wire

// File: rtl/layer_priority_sel.sv
`default_nettype none
// ============================================================================
// Module   : layer_priority_sel
// Purpose  : Combinational lowest-index-wins select over masked layer
//            requests; returns the winning colour and a hit flag.
// Revision : 1.0 - initial release
// ============================================================================
module layer_priority_sel #(
   parameter int NUM_LAYERS = 8,
   parameter int RGB_W      = 12
) (
   input  logic [NUM_LAYERS-1:0]       req,
   input  logic [NUM_LAYERS-1:0]       mask,
   input  logic [NUM_LAYERS*RGB_W-1:0] rgb,
   output logic [RGB_W-1:0]            win_rgb,
   output logic                        hit
);

   // Scan from the lowest priority upward so the lowest enabled index wins last.
   always_comb begin
      win_rgb = '0;
      hit     = 1'b0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (req[i] && mask[i]) begin
            win_rgb = rgb[i*RGB_W +: RGB_W];
            hit     = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : layer_compositor
// Purpose  : Two-stage per-pixel priority compositor with runtime layer mask
//            and an optional frame-timed fade-out/fade-in on state changes.
//            Optional feature macro: FADE_EN (fade FSM + stage-2 multiplier).
// Revision : 1.0 - initial release
// ============================================================================
module layer_compositor
   import game_pkg::*;
#(
   parameter int NUM_LAYERS = 8,
   parameter int COLOR_W    = RGB_CH_W,
   parameter int FADE_W     = 3
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [2:0]                          game_state,
   input  logic                                frame_start,
   input  logic [NUM_LAYERS-1:0]               layer_dr,
   input  logic [NUM_LAYERS*NUM_CH*COLOR_W-1:0] layer_rgb,
   input  logic                                layer_mask_we,
   input  logic [NUM_LAYERS-1:0]               layer_mask_wdata,
   input  logic                                screen_dr,
   input  logic [NUM_CH*COLOR_W-1:0]           screen_rgb,
   input  logic [NUM_CH*COLOR_W-1:0]           background_rgb,
   output logic [COLOR_W-1:0]                  red_level,
   output logic [COLOR_W-1:0]                  green_level,
   output logic [COLOR_W-1:0]                  blue_level,
   output logic                                fade_busy
);

   localparam int RGB_W = NUM_CH * COLOR_W;

   logic [NUM_LAYERS-1:0] mask_q, mask_d;
   logic [RGB_W-1:0]      rgb1_q, rgb1_d;
   logic [RGB_W-1:0]      out_q, out_d;
   logic [2:0]            sel_state;
   logic [RGB_W-1:0]      win_rgb;
   logic                  win_hit;

   layer_priority_sel #(
      .NUM_LAYERS (NUM_LAYERS),
      .RGB_W      (RGB_W)
   ) u_sel (
      .req     (layer_dr),
      .mask    (mask_q),
      .rgb     (layer_rgb),
      .win_rgb (win_rgb),
      .hit     (win_hit)
   );

   // Mask register loads on the write strobe; stage 1 picks the pixel colour.
   always_comb begin
      mask_d = layer_mask_we ? layer_mask_wdata : mask_q;
      rgb1_d = '0;
      if (sel_state == ST_PLAY) begin
         rgb1_d = win_hit ? win_rgb : background_rgb;
      end else if (sel_state == ST_START || sel_state == ST_WIN || sel_state == ST_OVER) begin
         rgb1_d = screen_dr ? screen_rgb : '0;
      end
   end

   // Pixel pipeline and mask registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '1;
         rgb1_q <= '0;
         out_q  <= '0;
      end else begin
         mask_q <= mask_d;
         rgb1_q <= rgb1_d;
         out_q  <= out_d;
      end
   end

`ifdef FADE_EN
   localparam int LVL_W = FADE_W + 1;
   localparam logic [LVL_W-1:0] LVL_MAX = {1'b1, {FADE_W{1'b0}}};
   localparam logic [LVL_W-1:0] LVL_ONE = {{FADE_W{1'b0}}, 1'b1};

   fade_state_t      fstate_q, fstate_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [2:0]       shown_q, shown_d;
   logic             fade_busy_q, fade_busy_d;

   // Fade sequencer: dims to black, swaps the shown state, then brightens.
   always_comb begin
      fstate_d = fstate_q;
      level_d  = level_q;
      shown_d  = shown_q;
      case (fstate_q)
         FS_IDLE: begin
            if (game_state != shown_q) fstate_d = FS_FADE_OUT;
         end
         FS_FADE_OUT: begin
            if (frame_start) begin
               if (level_q == '0) begin
                  // Black frame: swap the displayed state and hold level 0.
                  shown_d  = game_state;
                  fstate_d = FS_FADE_IN;
               end else begin
                  level_d = level_q - LVL_ONE;
               end
            end
         end
         FS_FADE_IN: begin
            if (game_state != shown_q) begin
               // Reverse immediately from the current level.
               fstate_d = FS_FADE_OUT;
               if (frame_start && level_q != '0) level_d = level_q - LVL_ONE;
            end else if (frame_start) begin
               level_d = level_q + LVL_ONE;
               if (level_d == LVL_MAX) fstate_d = FS_IDLE;
            end
         end
         default: fstate_d = FS_IDLE;
      endcase
      fade_busy_d = (fstate_d != FS_IDLE);
   end

   // Fade state, level, displayed state and busy flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fstate_q    <= FS_IDLE;
         level_q     <= LVL_MAX;
         shown_q     <= 3'd0;
         fade_busy_q <= 1'b0;
      end else begin
         fstate_q    <= fstate_d;
         level_q     <= level_d;
         shown_q     <= shown_d;
         fade_busy_q <= fade_busy_d;
      end
   end

   assign sel_state = shown_q;
   assign fade_busy = fade_busy_q;

   // Stage 2: scale each channel by level / 2^FADE_W.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      logic [COLOR_W+FADE_W:0] prod;
      assign prod = {{(FADE_W+1){1'b0}}, rgb1_q[c*COLOR_W +: COLOR_W]}
                  * {{COLOR_W{1'b0}}, level_q};
      assign out_d[c*COLOR_W +: COLOR_W] = COLOR_W'(prod >> FADE_W);
   end
`else
   logic unused_frame_start;

   // Displayed state follows game_state directly; level is fixed at full scale.
   assign sel_state          = game_state;
   assign out_d              = rgb1_q;
   assign fade_busy          = 1'b0;
   assign unused_frame_start = frame_start;
`endif

   assign red_level   = out_q[2*COLOR_W +: COLOR_W];
   assign green_level = out_q[1*COLOR_W +: COLOR_W];
   assign blue_level  = out_q[0 +: COLOR_W];

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_compositor
// Purpose  : Directed self-checking bench for layer_compositor (default
//            parameters; fade section active when FADE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  game_state;
   logic        frame_start;
   logic [7:0]  layer_dr;
   logic [95:0] layer_rgb;
   logic        layer_mask_we;
   logic [7:0]  layer_mask_wdata;
   logic        screen_dr;
   logic [11:0] screen_rgb;
   logic [11:0] background_rgb;
   logic [3:0]  red_level, green_level, blue_level;
   logic        fade_busy;
   logic [11:0] pix;

   int total = 0;
   int bad   = 0;

   assign pix = {red_level, green_level, blue_level};

   always #5 clk = ~clk;

   layer_compositor dut (
      .clk              (clk),
      .reset            (reset),
      .game_state       (game_state),
      .frame_start      (frame_start),
      .layer_dr         (layer_dr),
      .layer_rgb        (layer_rgb),
      .layer_mask_we    (layer_mask_we),
      .layer_mask_wdata (layer_mask_wdata),
      .screen_dr        (screen_dr),
      .screen_rgb       (screen_rgb),
      .background_rgb   (background_rgb),
      .red_level        (red_level),
      .green_level      (green_level),
      .blue_level       (blue_level),
      .fade_busy        (fade_busy)
   );

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle frame pulse, then two clocks so the new level reaches the outputs.
   task automatic pulse();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      tick();
   endtask

   task automatic go_play();
      game_state = 3'd2;
      tick();
`ifdef FADE_EN
      repeat (17) pulse();
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef FADE_EN
      logic [3:0] fade_r [17];
      fade_r = '{4'd13, 4'd11, 4'd9, 4'd7, 4'd5, 4'd3, 4'd1, 4'd0, 4'd0,
                 4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
`endif
      reset            = 1'b1;
      game_state       = 3'd0;
      frame_start      = 1'b0;
      layer_dr         = '0;
      layer_rgb        = '0;
      layer_mask_we    = 1'b0;
      layer_mask_wdata = '0;
      screen_dr        = 1'b0;
      screen_rgb       = '0;
      background_rgb   = '0;
      tick();
      tick();
      chk("reset_pix", pix, 12'h000);
      chk("reset_busy", {11'b0, fade_busy}, 12'h000);
      reset = 1'b0;

      background_rgb = 12'h00F;
      go_play();
      chk("busy_idle", {11'b0, fade_busy}, 12'h000);
      tick();
      tick();
      chk("bg", pix, 12'h00F);

      layer_rgb[0*12 +: 12] = 12'h123;
      layer_rgb[1*12 +: 12] = 12'hF00;
      layer_rgb[2*12 +: 12] = 12'h0F0;
      layer_rgb[7*12 +: 12] = 12'hABC;
      layer_dr = 8'b0000_0110;
      tick();
      chk("lat1", pix, 12'h00F);
      tick();
      chk("prio", pix, 12'hF00);

      layer_mask_wdata = 8'b1111_1101;
      layer_mask_we    = 1'b1;
      tick();
      layer_mask_we    = 1'b0;
      tick();
      tick();
      chk("mask", pix, 12'h0F0);

      layer_dr = 8'b1000_0001;
      tick();
      tick();
      chk("layer0", pix, 12'h123);
      layer_dr = 8'b1000_0000;
      tick();
      tick();
      chk("layer7", pix, 12'hABC);
      layer_dr = 8'b0000_0010;
      tick();
      tick();
      chk("masked_bg", pix, 12'h00F);
      layer_dr = 8'b0000_0000;
      tick();
      tick();
      chk("bg2", pix, 12'h00F);

`ifdef FADE_EN
      // Full fade play -> game over with a white play pixel and FF0 overlay.
      background_rgb = 12'hFFF;
      screen_dr      = 1'b1;
      screen_rgb     = 12'hFF0;
      tick();
      tick();
      chk("white", pix, 12'hFFF);
      game_state = 3'd4;
      tick();
      chk("busy_rise", {11'b0, fade_busy}, 12'h001);
      chk("fade_l8", pix, 12'hFFF);
      for (int k = 0; k < 17; k++) begin
         pulse();
         chk($sformatf("fade_%0d", k), pix,
             {fade_r[k], fade_r[k], (k < 8) ? fade_r[k] : 4'h0});
         chk($sformatf("fbusy_%0d", k), {11'b0, fade_busy},
             (k < 16) ? 12'h001 : 12'h000);
      end

      // Reversal during fade-in at level 3.
      game_state = 3'd2;
      tick();
      repeat (12) pulse();
      chk("fin_l3", pix, 12'h555);
      game_state = 3'd4;
      tick();
      chk("rev_busy", {11'b0, fade_busy}, 12'h001);
      tick();
      chk("rev_hold", pix, 12'h555);
      pulse();
      chk("rev_l2", pix, 12'h333);
      pulse();
      chk("rev_l1", pix, 12'h111);

      // Asynchronous reset mid-fade.
      #2;
      reset = 1'b1;
      #1;
      chk("rst_pix", pix, 12'h000);
      chk("rst_busy", {11'b0, fade_busy}, 12'h000);
      tick();
      reset      = 1'b0;
      game_state = 3'd2;
      tick();
      chk("rst_refade", {11'b0, fade_busy}, 12'h001);
      repeat (10) pulse();
      chk("rst_l1", pix, 12'h111);
      repeat (7) pulse();
      chk("rst_full", pix, 12'hFFF);
      chk("rst_idle", {11'b0, fade_busy}, 12'h000);
`else
      // Immediate state switching with no dimming.
      screen_dr  = 1'b1;
      screen_rgb = 12'hABC;
      game_state = 3'd3;
      tick();
      tick();
      chk("win_scr", pix, 12'hABC);
      chk("nofade_busy", {11'b0, fade_busy}, 12'h000);
      screen_dr = 1'b0;
      tick();
      tick();
      chk("win_noscr", pix, 12'h000);
      screen_dr  = 1'b1;
      screen_rgb = 12'h5A5;
      game_state = 3'd1;
      tick();
      tick();
      chk("start_scr", pix, 12'h5A5);
      game_state = 3'd4;
      tick();
      tick();
      chk("over_scr", pix, 12'h5A5);
      game_state = 3'd6;
      tick();
      tick();
      chk("bad_state", pix, 12'h000);
      game_state = 3'd0;
      tick();
      tick();
      chk("zero_state", pix, 12'h000);
      game_state = 3'd2;
      tick();
      tick();
      chk("back_play", pix, 12'h00F);

      // Asynchronous reset mid-run.
      #2;
      reset = 1'b1;
      #1;
      chk("rst_pix", pix, 12'h000);
      chk("rst_busy", {11'b0, fade_busy}, 12'h000);
      tick();
      reset = 1'b0;
      go_play();
`endif

      // Mask is back to all ones after reset.
      layer_dr = 8'b0000_0110;
      tick();
      tick();
      chk("mask_rst", pix, 12'hF00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
